// File: rtl/csr_timer_file.sv
// LoongArch-32 CSR file: exception CSRs, countdown timer, sampled interrupt lines,
// BADV capture and a 64-bit stable counter. Read by ID, written by WB.
module csr_timer_file #(
   parameter int          TIMER_W  = 32,
   parameter int          HW_INT_N = 8,
   parameter logic [31:0] TID_INIT = 32'h0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                csr_re,
   input  logic [13:0]         csr_num,
   output logic [31:0]         csr_rvalue,
   input  logic                csr_we,
   input  logic [31:0]         csr_wmask,
   input  logic [31:0]         csr_wvalue,
   input  logic                ertn_flush,
   input  logic                wb_ex,
   input  logic [5:0]          wb_ecode,
   input  logic [8:0]          wb_esubcode,
   input  logic [31:0]         wb_pc,
   input  logic [31:0]         wb_vaddr,
   input  logic [HW_INT_N-1:0] hw_int_in,
   input  logic                ipi_in,
   output logic [31:0]         ex_entry,
   output logic [31:0]         ertn_entry,
   output logic                has_int,
   output logic [63:0]         stable_cnt
);

   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_PRMD   = 14'h001;
   localparam logic [13:0] CSR_EUEN   = 14'h002;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00C;
   localparam logic [13:0] CSR_SAVE0  = 14'h030;
   localparam logic [13:0] CSR_SAVE1  = 14'h031;
   localparam logic [13:0] CSR_SAVE2  = 14'h032;
   localparam logic [13:0] CSR_SAVE3  = 14'h033;
   localparam logic [13:0] CSR_TID    = 14'h040;
   localparam logic [13:0] CSR_TCFG   = 14'h041;
   localparam logic [13:0] CSR_TVAL   = 14'h042;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   // LIE[10] is reserved in the architecture, so it stays 0.
   localparam logic [12:0] LIE_MASK = 13'h1BFF;

   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;

   // architectural state
   logic [1:0]          crmd_plv;
   logic                crmd_ie;
   logic [1:0]          prmd_pplv;
   logic                prmd_pie;
   logic                euen_fpe;
   logic [12:0]         ecfg_lie;
   logic [1:0]          estat_is_sw;
   logic [HW_INT_N-1:0] estat_is_hw;
   logic                estat_ti;
   logic                estat_ipi;
   logic [5:0]          estat_ecode;
   logic [8:0]          estat_esub;
   logic [31:0]         era;
   logic [31:0]         badv;
   logic [25:0]         eentry_va;
   logic [31:0]         save_q [4];
   logic [31:0]         tid;
   logic [TIMER_W-1:0]  tcfg_q;
   logic [TIMER_W-1:0]  cnt;
   logic [63:0]         stable_q;

   // read-side views of the registers
   logic [31:0] crmd_rd;
   logic [31:0] prmd_rd;
   logic [31:0] euen_rd;
   logic [31:0] ecfg_rd;
   logic [31:0] estat_rd;
   logic [31:0] tcfg_rd;
   logic [31:0] tval_rd;
   logic [7:0]  hw_is_rd;
   logic [12:0] estat_is_all;

   // write decode
   logic crmd_wr, prmd_wr, euen_wr, ecfg_wr, estat_wr, era_wr, badv_wr;
   logic eentry_wr, save_wr, tid_wr, tcfg_wr, ticlr_wr;
   logic ticlr_clr;
   logic timer_expire;
   logic badv_from_pc;
   logic badv_from_va;

   logic [31:0]        crmd_new, prmd_new, euen_new, ecfg_new, estat_new;
   logic [31:0]        era_new, badv_new, eentry_new, save_new, tid_new, tcfg_new;
   logic [TIMER_W-1:0] tcfg_new_w;
   logic [TIMER_W-1:0] reload_val;
   logic [TIMER_W-1:0] reload_new;

   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] mask,
                                         input logic [31:0] wval);
      merge = (mask & wval) | (~mask & old_v);
   endfunction

   always_comb begin
      hw_is_rd = '0;
      hw_is_rd[HW_INT_N-1:0] = estat_is_hw;
   end

   assign estat_is_all = {estat_ipi, estat_ti, 1'b0, hw_is_rd, estat_is_sw};

   // DA is hard-wired to 1; PG, DATF and DATM are not software-writable and read 0
   assign crmd_rd  = {28'd0, 1'b1, crmd_ie, crmd_plv};
   assign prmd_rd  = {29'd0, prmd_pie, prmd_pplv};
   assign euen_rd  = {31'd0, euen_fpe};
   assign ecfg_rd  = {19'd0, ecfg_lie};
   assign estat_rd = {1'b0, estat_esub, estat_ecode, 3'd0, estat_is_all};

   always_comb begin
      tcfg_rd = '0;
      tcfg_rd[TIMER_W-1:0] = tcfg_q;
      tval_rd = '0;
      tval_rd[TIMER_W-1:0] = cnt;
   end

   assign crmd_wr   = csr_we && (csr_num == CSR_CRMD);
   assign prmd_wr   = csr_we && (csr_num == CSR_PRMD);
   assign euen_wr   = csr_we && (csr_num == CSR_EUEN);
   assign ecfg_wr   = csr_we && (csr_num == CSR_ECFG);
   assign estat_wr  = csr_we && (csr_num == CSR_ESTAT);
   assign era_wr    = csr_we && (csr_num == CSR_ERA);
   assign badv_wr   = csr_we && (csr_num == CSR_BADV);
   assign eentry_wr = csr_we && (csr_num == CSR_EENTRY);
   assign save_wr   = csr_we && (csr_num[13:2] == CSR_SAVE0[13:2]);
   assign tid_wr    = csr_we && (csr_num == CSR_TID);
   assign tcfg_wr   = csr_we && (csr_num == CSR_TCFG);
   assign ticlr_wr  = csr_we && (csr_num == CSR_TICLR);
   assign ticlr_clr = ticlr_wr && csr_wmask[0] && csr_wvalue[0];

   assign crmd_new   = merge(crmd_rd, csr_wmask, csr_wvalue);
   assign prmd_new   = merge(prmd_rd, csr_wmask, csr_wvalue);
   assign euen_new   = merge(euen_rd, csr_wmask, csr_wvalue);
   assign ecfg_new   = merge(ecfg_rd, csr_wmask, csr_wvalue);
   assign estat_new  = merge(estat_rd, csr_wmask, csr_wvalue);
   assign era_new    = merge(era, csr_wmask, csr_wvalue);
   assign badv_new   = merge(badv, csr_wmask, csr_wvalue);
   assign eentry_new = merge({eentry_va, 6'd0}, csr_wmask, csr_wvalue);
   assign save_new   = merge(save_q[csr_num[1:0]], csr_wmask, csr_wvalue);
   assign tid_new    = merge(tid, csr_wmask, csr_wvalue);
   assign tcfg_new   = merge(tcfg_rd, csr_wmask, csr_wvalue);
   assign tcfg_new_w = tcfg_new[TIMER_W-1:0];

   assign reload_val = {tcfg_q[TIMER_W-1:2], 2'b00};
   assign reload_new = {tcfg_new_w[TIMER_W-1:2], 2'b00};

   // A TCFG write in the same cycle as cnt==0 suppresses the expiry.
   assign timer_expire = tcfg_q[0] && (cnt == '0) && !tcfg_wr;

   assign badv_from_pc = (wb_ecode == ECODE_ADE) && (wb_esubcode == 9'd0);
   assign badv_from_va = ((wb_ecode == ECODE_ADE) && (wb_esubcode == 9'd1)) ||
                         (wb_ecode == ECODE_ALE);

   // CRMD / PRMD: exception entry beats ertn, which beats software writes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         crmd_plv  <= 2'd0;
         crmd_ie   <= 1'b0;
         prmd_pplv <= 2'd0;
         prmd_pie  <= 1'b0;
      end else begin
         if (wb_ex) begin
            crmd_plv  <= 2'd0;
            crmd_ie   <= 1'b0;
            prmd_pplv <= crmd_plv;
            prmd_pie  <= crmd_ie;
         end else begin
            if (ertn_flush) begin
               crmd_plv <= prmd_pplv;
               crmd_ie  <= prmd_pie;
            end else if (crmd_wr) begin
               crmd_plv <= crmd_new[1:0];
               crmd_ie  <= crmd_new[2];
            end
            if (prmd_wr) begin
               prmd_pplv <= prmd_new[1:0];
               prmd_pie  <= prmd_new[2];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         euen_fpe  <= 1'b0;
         ecfg_lie  <= '0;
         eentry_va <= '0;
         tid       <= TID_INIT;
         for (int i = 0; i < 4; i++) save_q[i] <= '0;
      end else begin
         if (euen_wr)   euen_fpe  <= euen_new[0];
         if (ecfg_wr)   ecfg_lie  <= ecfg_new[12:0] & LIE_MASK;
         if (eentry_wr) eentry_va <= eentry_new[31:6];
         if (tid_wr)    tid       <= tid_new;
         if (save_wr)   save_q[csr_num[1:0]] <= save_new;
      end
   end

   // ESTAT: interrupt lines are re-sampled every cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         estat_is_sw <= 2'd0;
         estat_is_hw <= '0;
         estat_ipi   <= 1'b0;
         estat_ecode <= 6'd0;
         estat_esub  <= 9'd0;
      end else begin
         estat_is_hw <= hw_int_in;
         estat_ipi   <= ipi_in;
         if (estat_wr) estat_is_sw <= estat_new[1:0];
         if (wb_ex) begin
            estat_ecode <= wb_ecode;
            estat_esub  <= wb_esubcode;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         era  <= '0;
         badv <= '0;
      end else if (wb_ex) begin
         era <= wb_pc;
         if (badv_from_pc)      badv <= wb_pc;
         else if (badv_from_va) badv <= wb_vaddr;
      end else begin
         if (era_wr)  era  <= era_new;
         if (badv_wr) badv <= badv_new;
      end
   end

   // timer counter; one-shot expiry drops En and holds cnt at 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcfg_q <= '0;
         cnt    <= '0;
      end else if (tcfg_wr) begin
         tcfg_q <= tcfg_new_w;
         cnt    <= reload_new;
      end else if (tcfg_q[0]) begin
         if (cnt != '0)     cnt       <= cnt - TIMER_W'(1);
         else if (tcfg_q[1]) cnt      <= reload_val;
         else               tcfg_q[0] <= 1'b0;
      end
   end

   // expiry wins over a coincident TICLR clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)           estat_ti <= 1'b0;
      else if (timer_expire) estat_ti <= 1'b1;
      else if (ticlr_clr)    estat_ti <= 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) stable_q <= '0;
      else         stable_q <= stable_q + 64'd1;
   end

   always_comb begin
      csr_rvalue = '0;
      if (csr_re) begin
         case (csr_num)
            CSR_CRMD:   csr_rvalue = crmd_rd;
            CSR_PRMD:   csr_rvalue = prmd_rd;
            CSR_EUEN:   csr_rvalue = euen_rd;
            CSR_ECFG:   csr_rvalue = ecfg_rd;
            CSR_ESTAT:  csr_rvalue = estat_rd;
            CSR_ERA:    csr_rvalue = era;
            CSR_BADV:   csr_rvalue = badv;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'd0};
            CSR_SAVE0:  csr_rvalue = save_q[0];
            CSR_SAVE1:  csr_rvalue = save_q[1];
            CSR_SAVE2:  csr_rvalue = save_q[2];
            CSR_SAVE3:  csr_rvalue = save_q[3];
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = tcfg_rd;
            CSR_TVAL:   csr_rvalue = tval_rd;
            default:    csr_rvalue = '0;
         endcase
      end
   end

   assign ex_entry   = {eentry_va, 6'd0};
   assign ertn_entry = era;
   assign has_int    = crmd_ie && |(ecfg_lie & estat_is_all);
   assign stable_cnt = stable_q;

endmodule

// File: tb/tb_csr_timer_file.sv
// Directed bench for csr_timer_file: reset, timer modes, exceptions, interrupts,
// masked writes, and asynchronous reset mid-countdown.
`timescale 1ns/1ps
module tb_csr_timer_file;

   localparam logic [31:0] TID_RST = 32'h1234_5678;

   localparam logic [13:0] A_CRMD   = 14'h000;
   localparam logic [13:0] A_PRMD   = 14'h001;
   localparam logic [13:0] A_ECFG   = 14'h004;
   localparam logic [13:0] A_ESTAT  = 14'h005;
   localparam logic [13:0] A_ERA    = 14'h006;
   localparam logic [13:0] A_BADV   = 14'h007;
   localparam logic [13:0] A_EENTRY = 14'h00C;
   localparam logic [13:0] A_SAVE2  = 14'h032;
   localparam logic [13:0] A_TID    = 14'h040;
   localparam logic [13:0] A_TCFG   = 14'h041;
   localparam logic [13:0] A_TVAL   = 14'h042;
   localparam logic [13:0] A_TICLR  = 14'h044;

   logic        clk = 1'b0;
   logic        resetn;
   logic        csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        ertn_flush;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic [1:0]  hw_int_in;
   logic        ipi_in;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;
   logic        has_int;
   logic [63:0] stable_cnt;

   int errors = 0;
   int checks = 0;

   csr_timer_file #(.TIMER_W(32), .HW_INT_N(2), .TID_INIT(TID_RST)) dut (
      .clk(clk), .resetn(resetn),
      .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
      .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
      .ertn_flush(ertn_flush), .wb_ex(wb_ex),
      .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
      .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
      .hw_int_in(hw_int_in), .ipi_in(ipi_in),
      .ex_entry(ex_entry), .ertn_entry(ertn_entry),
      .has_int(has_int), .stable_cnt(stable_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [13:0] num, input logic [31:0] mask,
                            input logic [31:0] val);
      csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
      tick();
      csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
   endtask

   task automatic csr_read(input logic [13:0] num, output logic [31:0] val);
      csr_re = 1'b1; csr_num = num;
      #1;
      val = csr_rvalue;
      csr_re = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      resetn = 1'b0;
      csr_re = 0; csr_num = '0; csr_we = 0; csr_wmask = '0; csr_wvalue = '0;
      ertn_flush = 0; wb_ex = 0; wb_ecode = '0; wb_esubcode = '0;
      wb_pc = '0; wb_vaddr = '0; hw_int_in = '0; ipi_in = 0;
      repeat (2) @(posedge clk);
      #1;
      csr_read(A_CRMD, rd);
      if (rd !== 32'h8) begin errors++; $display("FAIL reset_crmd: got %h want %h", rd, 32'h8); end
      checks++;
      csr_read(A_TID, rd);
      if (rd !== TID_RST) begin errors++; $display("FAIL reset_tid: got %h want %h", rd, TID_RST); end
      checks++;
      if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int: got %b want 0", has_int); end
      checks++;
      if (ex_entry !== 32'h0 || ertn_entry !== 32'h0) begin
         errors++; $display("FAIL reset_entries: got %h/%h want 0/0", ex_entry, ertn_entry);
      end
      checks++;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      if (stable_cnt !== 64'd1) begin errors++; $display("FAIL stable_first: got %0d want 1", stable_cnt); end
      checks++;
      repeat (9) tick();
      if (stable_cnt !== 64'd10) begin errors++; $display("FAIL stable_ten: got %0d want 10", stable_cnt); end
      checks++;
   endtask

   task automatic test_one_shot();
      logic [31:0] rd;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h11);
      for (int i = 0; i <= 16; i++) begin
         csr_read(A_TVAL, rd);
         if (rd !== 32'(16 - i)) begin errors++; $display("FAIL oneshot_tval[%0d]: got %0d want %0d", i, rd, 16 - i); end
         checks++;
         if (i == 16) begin
            csr_read(A_ESTAT, rd);
            if (rd[11] !== 1'b0) begin errors++; $display("FAIL oneshot_ti_early: got %b want 0", rd[11]); end
            checks++;
         end
         tick();
      end
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b1) begin errors++; $display("FAIL oneshot_ti: got %b want 1", rd[11]); end
      checks++;
      csr_read(A_TCFG, rd);
      if (rd !== 32'h10) begin errors++; $display("FAIL oneshot_tcfg: got %h want %h", rd, 32'h10); end
      checks++;
      repeat (3) tick();
      csr_read(A_TVAL, rd);
      if (rd !== 32'h0) begin errors++; $display("FAIL oneshot_hold: got %h want 0", rd); end
      checks++;
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0) begin errors++; $display("FAIL oneshot_clear: got %b want 0", rd[11]); end
      checks++;
   endtask

   task automatic test_periodic();
      logic [31:0] rd;
      csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h800);
      csr_write(A_CRMD, 32'hFFFF_FFFF, 32'h4);
      csr_read(A_CRMD, rd);
      if (rd !== 32'hC) begin errors++; $display("FAIL periodic_crmd: got %h want %h", rd, 32'hC); end
      checks++;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h0B);
      for (int i = 0; i <= 8; i++) begin
         csr_read(A_ESTAT, rd);
         if (rd[11] !== 1'b0 || has_int !== 1'b0) begin
            errors++; $display("FAIL periodic_idle[%0d]: got ti=%b int=%b want 0/0", i, rd[11], has_int);
         end
         checks++;
         tick();
      end
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b1 || has_int !== 1'b1) begin
         errors++; $display("FAIL periodic_fire: got ti=%b int=%b want 1/1", rd[11], has_int);
      end
      checks++;
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0 || has_int !== 1'b0) begin
         errors++; $display("FAIL periodic_clear: got ti=%b int=%b want 0/0", rd[11], has_int);
      end
      checks++;
      repeat (7) tick();
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b1) begin errors++; $display("FAIL periodic_set_wins: got %b want 1", rd[11]); end
      checks++;
   endtask

   task automatic test_timer_edges();
      logic [31:0] rd;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h0);
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0) begin errors++; $display("FAIL edge_cleared: got %b want 0", rd[11]); end
      checks++;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h01);
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h09);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0) begin errors++; $display("FAIL edge_write_wins_ti: got %b want 0", rd[11]); end
      checks++;
      csr_read(A_TVAL, rd);
      if (rd !== 32'd8) begin errors++; $display("FAIL edge_write_wins_tval: got %0d want 8", rd); end
      checks++;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h03);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0) begin errors++; $display("FAIL edge_zero_pre: got %b want 0", rd[11]); end
      checks++;
      tick();
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b1) begin errors++; $display("FAIL edge_zero_fire: got %b want 1", rd[11]); end
      checks++;
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b1) begin errors++; $display("FAIL edge_zero_refire: got %b want 1", rd[11]); end
      checks++;
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h0);
      csr_write(A_TICLR, 32'h1, 32'h1);
      csr_read(A_ESTAT, rd);
      if (rd[11] !== 1'b0) begin errors++; $display("FAIL edge_final_clear: got %b want 0", rd[11]); end
      checks++;
   endtask

   task automatic test_exception();
      logic [31:0] rd;
      csr_write(A_CRMD, 32'hFFFF_FFFF, 32'h7);
      csr_read(A_CRMD, rd);
      if (rd !== 32'hF) begin errors++; $display("FAIL exc_pre_crmd: got %h want %h", rd, 32'hF); end
      checks++;
      wb_ex = 1; wb_ecode = 6'h09; wb_esubcode = 9'd0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h1003;
      csr_we = 1; csr_num = A_CRMD; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h3;
      tick();
      wb_ex = 0; csr_we = 0; csr_wmask = '0; csr_wvalue = '0;
      csr_read(A_CRMD, rd);
      if (rd !== 32'h8) begin errors++; $display("FAIL exc_crmd: got %h want %h", rd, 32'h8); end
      checks++;
      csr_read(A_PRMD, rd);
      if (rd !== 32'h7) begin errors++; $display("FAIL exc_prmd: got %h want %h", rd, 32'h7); end
      checks++;
      csr_read(A_BADV, rd);
      if (rd !== 32'h1003) begin errors++; $display("FAIL exc_badv_ale: got %h want %h", rd, 32'h1003); end
      checks++;
      csr_read(A_ESTAT, rd);
      if (rd[21:16] !== 6'h09) begin errors++; $display("FAIL exc_ecode: got %h want %h", rd[21:16], 6'h09); end
      checks++;
      if (ertn_entry !== 32'h1C00_0100) begin errors++; $display("FAIL exc_era: got %h want %h", ertn_entry, 32'h1C00_0100); end
      checks++;
      ertn_flush = 1;
      tick();
      ertn_flush = 0;
      csr_read(A_CRMD, rd);
      if (rd !== 32'hF) begin errors++; $display("FAIL ertn_crmd: got %h want %h", rd, 32'hF); end
      checks++;
      wb_ex = 1; wb_ecode = 6'h08; wb_esubcode = 9'd0; wb_pc = 32'h2000; wb_vaddr = 32'h3000;
      tick();
      csr_read(A_BADV, rd);
      if (rd !== 32'h2000) begin errors++; $display("FAIL exc_badv_adef: got %h want %h", rd, 32'h2000); end
      checks++;
      wb_ecode = 6'h0B; wb_esubcode = 9'd0; wb_pc = 32'h4000; wb_vaddr = 32'h5000;
      tick();
      csr_read(A_BADV, rd);
      if (rd !== 32'h2000) begin errors++; $display("FAIL exc_badv_keep: got %h want %h", rd, 32'h2000); end
      checks++;
      csr_read(A_ERA, rd);
      if (rd !== 32'h4000) begin errors++; $display("FAIL exc_era_sys: got %h want %h", rd, 32'h4000); end
      checks++;
      wb_ecode = 6'h08; wb_esubcode = 9'd1; wb_pc = 32'h7000; wb_vaddr = 32'h6000;
      tick();
      wb_ex = 0;
      csr_read(A_BADV, rd);
      if (rd !== 32'h6000) begin errors++; $display("FAIL exc_badv_adem: got %h want %h", rd, 32'h6000); end
      checks++;
      csr_read(A_ESTAT, rd);
      if (rd[30:22] !== 9'd1) begin errors++; $display("FAIL exc_esub: got %h want 1", rd[30:22]); end
      checks++;
      csr_write(A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8FFF);
      csr_read(A_EENTRY, rd);
      if (rd !== 32'h1C00_8FC0 || ex_entry !== 32'h1C00_8FC0) begin
         errors++; $display("FAIL eentry: got %h/%h want %h", rd, ex_entry, 32'h1C00_8FC0);
      end
      checks++;
   endtask

   task automatic test_hw_int();
      logic [31:0] rd;
      csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h8);
      csr_write(A_CRMD, 32'h7, 32'h4);
      hw_int_in = 2'b10;
      #1;
      if (has_int !== 1'b0) begin errors++; $display("FAIL hw_latency: got %b want 0", has_int); end
      checks++;
      tick();
      csr_read(A_ESTAT, rd);
      if (rd[3] !== 1'b1 || rd[9:4] !== 6'd0 || rd[2] !== 1'b0) begin
         errors++; $display("FAIL hw_is: got %b want 0000010", rd[9:2]);
      end
      checks++;
      if (has_int !== 1'b1) begin errors++; $display("FAIL hw_has_int: got %b want 1", has_int); end
      checks++;
      hw_int_in = 2'b01;
      tick();
      csr_read(A_ESTAT, rd);
      if (rd[3:2] !== 2'b01 || has_int !== 1'b0) begin
         errors++; $display("FAIL hw_unmasked_line: got is=%b int=%b want 01/0", rd[3:2], has_int);
      end
      checks++;
      hw_int_in = 2'b00;
      ipi_in = 1;
      csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h1000);
      csr_read(A_ESTAT, rd);
      if (rd[12] !== 1'b1 || has_int !== 1'b1) begin
         errors++; $display("FAIL ipi: got is12=%b int=%b want 1/1", rd[12], has_int);
      end
      checks++;
      csr_write(A_CRMD, 32'h7, 32'h0);
      if (has_int !== 1'b0) begin errors++; $display("FAIL ie_gate: got %b want 0", has_int); end
      checks++;
      ipi_in = 0;
   endtask

   task automatic test_masked();
      logic [31:0] rd;
      csr_write(A_SAVE2, 32'hFFFF_FFFF, 32'hFFFF_0000);
      csr_write(A_SAVE2, 32'h0000_FFFF, 32'h0000_1234);
      csr_read(A_SAVE2, rd);
      if (rd !== 32'hFFFF_1234) begin errors++; $display("FAIL masked_save2: got %h want %h", rd, 32'hFFFF_1234); end
      checks++;
      csr_write(A_TVAL, 32'hFFFF_FFFF, 32'h55);
      csr_read(A_TVAL, rd);
      if (rd !== 32'h0) begin errors++; $display("FAIL tval_ro: got %h want 0", rd); end
      checks++;
      csr_write(14'h03F, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
      csr_read(14'h03F, rd);
      if (rd !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want 0", rd); end
      checks++;
      csr_read(A_TICLR, rd);
      if (rd !== 32'h0) begin errors++; $display("FAIL ticlr_read: got %h want 0", rd); end
      checks++;
      csr_re = 0; csr_num = A_SAVE2;
      #1;
      if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL re_low: got %h want 0", csr_rvalue); end
      checks++;
      csr_write(A_TID, 32'hFFFF_FFFF, 32'hABCD_0000);
      csr_read(A_TID, rd);
      if (rd !== 32'hABCD_0000) begin errors++; $display("FAIL tid_write: got %h want %h", rd, 32'hABCD_0000); end
      checks++;
   endtask

   task automatic test_reset_midcount();
      logic [31:0] rd;
      csr_write(A_ECFG, 32'hFFFF_FFFF, 32'h1);
      csr_write(A_ESTAT, 32'h3, 32'h1);
      csr_write(A_CRMD, 32'h7, 32'h4);
      csr_write(A_TCFG, 32'hFFFF_FFFF, 32'h41);
      repeat (5) tick();
      csr_read(A_TVAL, rd);
      if (rd !== 32'd59 || has_int !== 1'b1) begin
         errors++; $display("FAIL midcount_pre: got tval=%0d int=%b want 59/1", rd, has_int);
      end
      checks++;
      #2;
      resetn = 1'b0;
      #1;
      csr_read(A_CRMD, rd);
      if (rd !== 32'h8) begin errors++; $display("FAIL async_crmd: got %h want %h", rd, 32'h8); end
      checks++;
      csr_read(A_TVAL, rd);
      if (rd !== 32'h0) begin errors++; $display("FAIL async_tval: got %h want 0", rd); end
      checks++;
      csr_read(A_TID, rd);
      if (rd !== TID_RST) begin errors++; $display("FAIL async_tid: got %h want %h", rd, TID_RST); end
      checks++;
      if (stable_cnt !== 64'd0 || has_int !== 1'b0) begin
         errors++; $display("FAIL async_cnt_int: got cnt=%0d int=%b want 0/0", stable_cnt, has_int);
      end
      checks++;
      if (ex_entry !== 32'h0 || ertn_entry !== 32'h0) begin
         errors++; $display("FAIL async_entries: got %h/%h want 0/0", ex_entry, ertn_entry);
      end
      checks++;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      csr_read(A_TVAL, rd);
      if (rd !== 32'h0 || stable_cnt !== 64'd1) begin
         errors++; $display("FAIL post_reset: got tval=%0d cnt=%0d want 0/1", rd, stable_cnt);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_timer_edges();
      test_exception();
      test_hw_int();
      test_masked();
      test_reset_midcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csr_timer_file.md
# csr_timer_file

Parametrised control-and-status register file for the LoongArch-32 pipeline, the successor to the basic exception CSR set. It adds a configurable-width countdown timer (TID/TCFG/TVAL/TICLR), a configurable number of sampled hardware interrupt lines plus an IPI line, BADV capture, and a 64-bit stable counter for `rdcntv*`. It sits beside WB: ID reads it and WB writes it; it drives the exception/ertn entry vectors and `has_int` to ID.

## Interface
- `TIMER_W`, 32, timer/TVAL width (8..32); TCFG.InitVal occupies bits `[TIMER_W-1:2]`.
- `HW_INT_N`, 8, number of hardware interrupt inputs (1..8), mapped to ESTAT.IS[2+HW_INT_N-1:2].
- `TID_INIT`, 32'h0, TID reset value.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `csr_re`  in  1  read enable; when low, `csr_rvalue` = 0.
- `csr_num`  in  14  CSR address.
- `csr_rvalue`  out  32  combinational read data; 0 for unmapped addresses.
- `csr_we`, `csr_wmask`, `csr_wvalue`  in  1/32/32  masked write: new = mask&wvalue | ~mask&old.
- `ertn_flush`  in  1  ertn retiring in WB.
- `wb_ex`  in  1  exception retiring in WB.
- `wb_ecode`, `wb_esubcode`  in  6/9  exception codes.
- `wb_pc`, `wb_vaddr`  in  32/32  faulting PC and data address.
- `hw_int_in`  in  HW_INT_N  level hardware interrupts.
- `ipi_in`  in  1  inter-processor interrupt level.
- `ex_entry`, `ertn_entry`  out  32/32  EENTRY and ERA values.
- `has_int`  out  1  CRMD.IE & |(ECFG.LIE & ESTAT.IS).
- `stable_cnt`  out  64  free-running counter.

## Operation
- Address map: CRMD 0x0, PRMD 0x1, EUEN 0x2, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42 (read-only), TICLR 0x44 (reads 0).
- CRMD: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7]. Only PLV and IE are writable by software. On `wb_ex`: PLV←0, IE←0, and PRMD←{old IE, old PLV}. On `ertn_flush`: PLV/IE←PRMD.
- ESTAT: IS[1:0] is software-writable. IS[2+k] ← `hw_int_in[k]`, sampled every cycle; unused IS[9:2+HW_INT_N] read 0. IS[11] = timer interrupt (TI). IS[12] ← `ipi_in`, sampled. On `wb_ex`: Ecode[21:16]←`wb_ecode`, EsubCode[30:22]←`wb_esubcode`.
- ERA ← `wb_pc` on `wb_ex`.
- BADV on `wb_ex`: if ecode=0x08 & esubcode=0 (ADEF), BADV←`wb_pc`; if ecode=0x08 & esubcode=1 (ADEM) or ecode=0x09 (ALE), BADV←`wb_vaddr`; otherwise unchanged.
- EENTRY holds VA[31:6]; bits [5:0] read 0.
- Timer: a TCFG write loads cnt←{InitVal,2'b00}. While En=1: if cnt≠0, cnt←cnt−1. When cnt=0, TI←1, and then either cnt←{InitVal,2'b00} (Periodic=1) or En←0 with cnt held at 0 (one-shot). TVAL reads cnt zero-extended to 32 bits. A TICLR write with mask[0]&wvalue[0] clears TI.
- `stable_cnt` increments by 1 every cycle and wraps at 2^64.

## Timing
- Writes and event updates take effect on the next edge; reads are combinational with no write bypass.
- Reset (asynchronous, any cycle including mid-countdown): CRMD=0x8 (DA=1). PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TCFG, cnt, and `stable_cnt` are 0. TID=`TID_INIT`. Hence `has_int`=0, `ex_entry`=0, `ertn_entry`=0.
- Priority: `wb_ex` > `ertn_flush` > software write (CRMD/PRMD/ERA/ESTAT.Ecode/BADV).
- Timer expiry and a TICLR clear in the same cycle: the set wins (TI=1).
- A TCFG write in the same cycle as cnt=0: the write wins; no TI set, and the counter reloads from the new value.
- `hw_int_in`/`ipi_in` to `has_int`: 1 cycle of latency (registered sample).
- InitVal=0 with En=1: TI sets on the first enabled cycle; periodic mode then re-asserts TI every cycle.

## Test plan
- Reset: pulse `resetn` low mid-countdown -> CRMD reads 0x8, TVAL 0, TID=`TID_INIT`, `stable_cnt`=0, `has_int`=0 (asynchronously, before the next edge).
- One-shot timer: write TCFG=0x11 (InitVal=4, En=1) -> TVAL counts 16,15,…,0; TI set 17 cycles after the write; TCFG reads 0x10; TVAL stays 0.
- Periodic timer with ECFG.LIE[11]=1, CRMD.IE=1: TCFG=0x0B -> TI and `has_int` rise every 9 cycles; TICLR write of 1 clears TI; a clear coincident with expiry leaves TI=1.
- Exception: CRMD.PLV=3, IE=1, `wb_ex` with ecode 0x09, `wb_vaddr`=0x1003 -> CRMD PLV/IE=0, PRMD=0x7, BADV=0x1003, ESTAT[21:16]=0x09; a simultaneous CRMD write is ignored; `ertn_flush` then restores PLV=3, IE=1.
- HW interrupt with `HW_INT_N`=2: `hw_int_in`=2'b10 -> ESTAT.IS[3]=1 one cycle later; IS[9:4] read 0; `has_int` follows LIE[3]&IE.
- Masked write: SAVE2=0xFFFF0000, then write wvalue 0x1234, mask 0x0000FFFF -> reads 0xFFFF1234; TVAL write ignored; unmapped address 0x3F reads 0.
